pclk_rate_ctrl: RTL

- Sequencer for the common clock block.
- Owns the DataBusWidth value that selects the PCLK divide ratio (8->/10, 16->/20, 32->/40).
- Owns the active-low reset driven into the clock dividers.
- Serialises width-change requests from the PHY/MAC side. Each change follows the same sequence: drain, hold dividers in reset, apply the new width, settle, then signal PCLK ready. Runs on Ref_Clk.

---
 rtl/pclk_rate_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pclk_rate_ctrl.sv
// rtl/pclk_rate_ctrl.sv - PCLK rate sequencer: serialises bus-width changes around a divider reset.
// Optional feature macro PCLK_RATE_CFG_LOCK_EN adds cfg_lock, which rejects every request while high.
module pclk_rate_ctrl #(
    parameter int LOCK_CYCLES    = 64,
    parameter int DRAIN_CYCLES   = 8,
    parameter int DIV_RST_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEFAULT_WIDTH  = 8
) (
    input  logic       Ref_Clk,
    input  logic       rst,
`ifdef PCLK_RATE_CFG_LOCK_EN
    input  logic       cfg_lock,
`endif
    input  logic       width_req,
    input  logic [5:0] width_req_val,
    output logic       width_ack,
    output logic       width_err,
    output logic [5:0] DataBusWidth,
    output logic       Div_Rst_n,
    output logic       pclk_ready,
    output logic       busy
);
    localparam int MAX_A   = (LOCK_CYCLES > DRAIN_CYCLES) ? LOCK_CYCLES : DRAIN_CYCLES;
    localparam int MAX_B   = (DIV_RST_CYCLES > SETTLE_CYCLES) ? DIV_RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] DIVRST_LAST = CW'(DIV_RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [5:0]    DEF_W       = 6'(DEFAULT_WIDTH);

    typedef enum logic [2:0] {
        PLL_WAIT = 3'd0,
        SETTLE   = 3'd1,
        RUN      = 3'd2,
        DRAIN    = 3'd3,
        DIV_RST  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    width_q, width_d;
    logic [5:0]    pend_q, pend_d;
    logic          from_chg_q, from_chg_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          lock_w;
    logic          legal_w;

`ifdef PCLK_RATE_CFG_LOCK_EN
    assign lock_w = cfg_lock;
`else
    assign lock_w = 1'b0;
`endif

    assign legal_w = (width_req_val == 6'd8) || (width_req_val == 6'd16) || (width_req_val == 6'd32);

    always_ff @(posedge Ref_Clk) begin
        if (rst) begin
            state_q    <= PLL_WAIT;
            cnt_q      <= '0;
            width_q    <= DEF_W;
            pend_q     <= DEF_W;
            from_chg_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            pend_q     <= pend_d;
            from_chg_q <= from_chg_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        width_d    = width_q;
        pend_d     = pend_q;
        from_chg_d = from_chg_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            PLL_WAIT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d    = SETTLE;
                    cnt_d      = '0;
                    from_chg_d = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    ack_d   = from_chg_q;
                end
            end
            RUN: begin
                cnt_d = '0;
                // A request still held during the response pulse is the old one; skip it.
                if (width_req && !ack_q && !err_q) begin
                    if (lock_w || !legal_w) begin
                        err_d = 1'b1;
                    end else if (width_req_val == width_q) begin
                        ack_d = 1'b1;
                    end else begin
                        pend_d  = width_req_val;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DIV_RST;
                    cnt_d   = '0;
                    width_d = pend_q;
                end
            end
            DIV_RST: begin
                if (cnt_q == DIVRST_LAST) begin
                    state_d    = SETTLE;
                    cnt_d      = '0;
                    from_chg_d = 1'b1;
                end
            end
            default: begin
                state_d = PLL_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign width_ack    = ack_q;
    assign width_err    = err_q;
    assign DataBusWidth = width_q;
    assign Div_Rst_n    = (state_q != PLL_WAIT) && (state_q != DIV_RST);
    assign pclk_ready   = (state_q == RUN);
    assign busy         = (state_q != RUN);

endmodule
